// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the SHA-256 message-schedule controller and its
// producer/consumer.
//   start, abort, block_in : block load / cancel controls (master -> slave)
//   ready                  : round datapath accepts w_out  (master -> slave)
//   w_out, w_valid         : schedule word stream          (slave -> master)
//   round_idx              : index t of w_out              (slave -> master)
//   busy, done             : block status / end pulse      (slave -> master)
interface sha256_msg_sched_if;
    logic         start;
    logic         abort;
    logic [511:0] block_in;
    logic         ready;
    logic [31:0]  w_out;
    logic         w_valid;
    logic [5:0]   round_idx;
    logic         busy;
    logic         done;

    modport slave (
        input  start, abort, block_in, ready,
        output w_out, w_valid, round_idx, busy, done
    );

    modport master (
        output start, abort, block_in, ready,
        input  w_out, w_valid, round_idx, busy, done
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule controller.
// Loads one 512-bit block and streams W[0..ROUNDS-1] over a valid/ready
// handshake, one word per accepted cycle. A 16-entry circular buffer holds
// the sliding window; each new word is written back into the slot of the
// word that just fell out of the window (t % 16).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : sha256_msg_sched_if.slave (start/abort/block_in/ready in,
//            w_out/w_valid/round_idx/busy/done out)
module sha256_msg_sched #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_msg_sched_if.slave    bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] wbuf [16];
    logic [5:0]  t;
    logic        done_q;

    logic [3:0]  t4;
    logic [3:0]  i_m2;
    logic [3:0]  i_m7;
    logic [3:0]  i_m15;
    logic [31:0] w_calc;
    logic [31:0] w_word;
    logic        last;
    logic        load;
    logic        xfer;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Window taps W[t-2], W[t-7], W[t-15], W[t-16] live at (t+14), (t+9),
    // (t+1) and t modulo 16; 4-bit arithmetic gives the wrap for free.
    always_comb begin
        t4     = t[3:0];
        i_m2   = t4 + 4'd14;
        i_m7   = t4 + 4'd9;
        i_m15  = t4 + 4'd1;
        w_calc = ssig1(wbuf[i_m2]) + wbuf[i_m7] + ssig0(wbuf[i_m15]) + wbuf[t4];
        w_word = (t < 6'd16) ? wbuf[t4] : w_calc;
        last   = (t == 6'(ROUNDS - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks both a transfer and start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start && !bus.abort) state_nxt = RUN;
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (xfer && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.w_valid   = (state == RUN);
        bus.busy      = (state == RUN);
        bus.w_out     = (state == RUN) ? w_word : '0;
        bus.round_idx = t;
        bus.done      = done_q;
        load          = (state == IDLE) && bus.start && !bus.abort;
        xfer          = (state == RUN) && bus.ready && !bus.abort;
    end

    // Window buffer, word index and end-of-block pulse. t is not advanced on
    // the final transfer so round_idx keeps showing ROUNDS-1 while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                wbuf[i] <= '0;
            end
            t      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (load) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    wbuf[i] <= bus.block_in[511 - 32*i -: 32];
                end
                t <= '0;
            end else if (xfer) begin
                wbuf[t4] <= w_word;
                if (!last) begin
                    t <= t + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: stimulus pushes expected words into
// a queue, an independent monitor pops and compares on every transfer.
module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha256_msg_sched_if bus();

    sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic [31:0] w;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          exp_done = 0;
    logic [31:0] wm [64];
    logic [511:0] abc_blk;
    logic [511:0] blk2;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ts0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ts1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    // Reference schedule from the textbook recurrence over a flat 64-word array
    task automatic model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) wm[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            wm[i] = ts1(wm[i-2]) + wm[i-7] + ts0(wm[i-15]) + wm[i-16];
    endtask

    task automatic push_all();
        for (int i = 0; i < ROUNDS; i++) exp_q.push_back('{idx: i, w: wm[i]});
    endtask

    // Monitor
    logic        prev_stall = 1'b0;
    logic [31:0] prev_w;
    logic [5:0]  prev_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.w_valid) begin
                check("stall_w_out", bus.w_out, prev_w);
                check("stall_round_idx", bus.round_idx, prev_idx);
            end
            if (bus.w_valid && bus.ready && !bus.abort) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got idx %0d w 0x%0h expected no transfer",
                             bus.round_idx, bus.w_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("w_out", bus.w_out, mon_e.w);
                    check("round_idx", bus.round_idx, mon_e.idx);
                end
            end
            prev_stall = bus.w_valid && !bus.ready && !bus.abort;
            prev_w     = bus.w_out;
            prev_idx   = bus.round_idx;
            if (bus.done) begin
                n_done++;
                check("done_busy", bus.busy, 0);
                check("done_w_valid", bus.w_valid, 0);
            end
        end
    end

    task automatic check_zero(input string nm);
        check({nm, "_w_valid"}, bus.w_valid, 0);
        check({nm, "_w_out"}, bus.w_out, 0);
        check({nm, "_round_idx"}, bus.round_idx, 0);
        check({nm, "_busy"}, bus.busy, 0);
        check({nm, "_done"}, bus.done, 0);
    endtask

    // Runs one block from a start pulse. start_at/abort_at/reset_at fire at
    // that round index (-1 disables); exp_cyc is the expected cycle count
    // from first w_valid to done.
    task automatic run_block(input logic [511:0] blk, input bit alt, input int start_at,
                             input int abort_at, input int reset_at, input int exp_cyc,
                             input string nm);
        int cyc;
        bit fin;
        push_all();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.block_in = blk;
        bus.ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({nm, "_first_valid"}, bus.w_valid, 1);
        check({nm, "_first_idx"}, bus.round_idx, 0);
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 400) begin
            bus.ready = alt ? 1'(cyc % 2) : 1'b1;
            bus.start = (bus.round_idx == start_at);
            if (bus.start) bus.block_in = ~blk;
            bus.abort = (bus.round_idx == abort_at);
            if (bus.round_idx == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_zero({nm, "_rst"});
                check({nm, "_rst_left"}, exp_q.size(), ROUNDS - reset_at);
                exp_q.delete();
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                bus.start = 1'b0;
                if (bus.abort) begin
                    bus.abort = 1'b0;
                    check({nm, "_w_valid"}, bus.w_valid, 0);
                    check({nm, "_done"}, bus.done, 0);
                    check({nm, "_busy"}, bus.busy, 0);
                    check({nm, "_left"}, exp_q.size(), ROUNDS - abort_at);
                    exp_q.delete();
                    fin = 1'b1;
                end else if (bus.done) begin
                    check({nm, "_done_cycles"}, cyc, exp_cyc);
                    fin = 1'b1;
                end
            end
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected %0d", nm, cyc, exp_cyc);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.ready    = 1'b0;
        bus.block_in = '0;
        #2;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_w_valid", bus.w_valid, 0);
        check("idle_busy", bus.busy, 0);

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        model(abc_blk);
        wm[16] = 32'h61626380;
        wm[17] = 32'h000F0000;
        wm[18] = 32'h7DA86405;
        wm[19] = 32'h600003C6;

        run_block(abc_blk, 1'b0, -1, -1, -1, 64, "abc");
        exp_done++;
        check("abc_idle_idx", bus.round_idx, ROUNDS - 1);

        run_block(abc_blk, 1'b1, -1, -1, -1, 128, "alt");
        exp_done++;

        run_block(abc_blk, 1'b0, 20, -1, -1, 64, "start_busy");
        exp_done++;

        run_block(abc_blk, 1'b0, -1, 30, -1, 0, "abort");
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_done", bus.done, 0);
        end
        check("abort_idle_idx", bus.round_idx, 30);

        run_block(abc_blk, 1'b0, -1, -1, -1, 64, "after_abort");
        exp_done++;

        run_block(abc_blk, 1'b0, -1, -1, 40, 0, "midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_w_valid", bus.w_valid, 0);
            check("post_rst_busy", bus.busy, 0);
        end

        for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = (32'h01010101 * i) ^ 32'hDEADBEEF;
        model(blk2);
        push_all();
        push_all();
        bus.start    = 1'b1;
        bus.block_in = blk2;
        bus.ready    = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held_done_cycles_1", cyc, 64);
        exp_done++;
        @(posedge clk); #1;
        check("held_restart_valid", bus.w_valid, 1);
        check("held_restart_idx", bus.round_idx, 0);
        check("held_restart_busy", bus.busy, 1);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held_done_cycles_2", cyc, 64);
        exp_done++;
        bus.ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("done_count", n_done, exp_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
